// File: rtl/enc_pkg.sv
// Shared helpers and the stage-1 payload type for the pipelined priority/Gray encoder.
package enc_pkg;

  // Widest index the stage-1 payload can carry (covers N up to 65536).
  localparam int unsigned IDX_MAX_W = 16;

  function automatic int unsigned code_w(input int unsigned n);
    return 32'($clog2(n)) + 32'd1;
  endfunction

  function automatic logic [31:0] to_gray(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 none;
    logic                 multi;
    logic                 gray_sel;
  } s1_payload_t;

endpackage

// File: rtl/prio_scan.sv
// Combinational scan of a request word: highest set index plus empty/multi-hot flags.
module prio_scan #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     in_data,
  output logic [IDX_W-1:0] idx_c,
  output logic             none_c,
  output logic             multi_c
);

  // Ascending scan so the last hit, i.e. the highest index, wins.
  always_comb begin
    idx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_data[i]) begin
        idx_c = IDX_W'(i);
      end
    end
  end

  assign none_c  = ~|in_data;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi_c = |(in_data & (in_data - N'(1)));

endmodule

// File: rtl/gray_prio_encoder.sv
// Two-stage valid/ready priority encoder emitting a Gray or binary position code per word,
// with multi-hot/empty flags and a saturating multi-hot counter.
module gray_prio_encoder
  import enc_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = code_w(N),
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             gray_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_multi,
  output logic             out_none,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0] scan_idx;
  logic             scan_none;
  logic             scan_multi;

  prio_scan #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_prio_scan (
    .in_data (in_data),
    .idx_c   (scan_idx),
    .none_c  (scan_none),
    .multi_c (scan_multi)
  );

  logic        s1_valid_q, s1_valid_d;
  s1_payload_t s1_q, s1_d;

  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] code_q, code_d;
  logic         multi_q, multi_d;
  logic         none_q, none_d;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic s2_ready_c;
  logic s1_ready_c;
  logic accept_c;

  // Ready chain: a stage can take a word if empty or if its occupant leaves this cycle.
  assign s2_ready_c = !s2_valid_q || out_ready;
  assign s1_ready_c = !s1_valid_q || s2_ready_c;
  assign in_ready   = s1_ready_c && !reset;
  assign accept_c   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_ready_c) begin
      s1_valid_d = accept_c;
    end
    if (accept_c) begin
      s1_d.idx      = IDX_MAX_W'(scan_idx);
      s1_d.none     = scan_none;
      s1_d.multi    = scan_multi;
      s1_d.gray_sel = gray_sel;
    end
  end

  // Position p = N - idx, or 0 for an empty word; gray_sel picked when the word was accepted.
  always_comb begin
    s2_valid_d = s2_valid_q;
    code_d     = code_q;
    multi_d    = multi_q;
    none_d     = none_q;
    if (s2_ready_c) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_ready_c && s1_valid_q) begin
      multi_d = s1_q.multi;
      none_d  = s1_q.none;
      if (s1_q.none) begin
        code_d = '0;
      end else if (s1_q.gray_sel) begin
        code_d = W'(to_gray(32'(N) - 32'(s1_q.idx)));
      end else begin
        code_d = W'(32'(N) - 32'(s1_q.idx));
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept_c && scan_multi && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      code_q     <= '0;
      multi_q    <= 1'b0;
      none_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      code_q     <= code_d;
      multi_q    <= multi_d;
      none_q     <= none_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_code  = code_q;
  assign out_multi = multi_q;
  assign out_none  = none_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/gray_prio_encoder.md
# gray_prio_encoder

Parametrised, pipelined successor to the team's 8-to-4 one-hot Gray encoder. It accepts an N-bit request word through a valid/ready handshake and resolves the highest set bit. It emits a position code in Gray or binary form, selected per word, two cycles later, and flags multi-hot and empty inputs. A saturating counter records how many multi-hot words were seen. It sits between request-generating logic and any consumer that wants a compact, glitch-safe position code.

## Interface
- N, default 8: request word width; must be at least 2.
- W, default $clog2(N)+1: code width, fixed by N and not to be overridden.
- CNT_W, default 8: width of the multi-hot error counter.

- clk  in  1  clock; all logic acts on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  the request word on in_data is valid.
- in_ready  out  1  the block can accept a word this cycle.
- in_data  in  N  request word.
- gray_sel  in  1  1 selects a Gray code, 0 selects a binary code; sampled with the word.
- out_valid  out  1  the output fields hold a result.
- out_ready  in  1  the consumer takes the result this cycle.
- out_code  out  W  position code.
- out_multi  out  1  more than one bit was set in the source word.
- out_none  out  1  the source word was all zero.
- err_clr  in  1  clears err_cnt.
- err_cnt  out  CNT_W  number of accepted multi-hot words, saturating.

## Operation
- A word is accepted when in_valid and in_ready are both 1 in the same cycle.
- Priority: the highest set index i wins; bit N-1 has top priority.
- Position value: p = N - i, so p ranges from 1 to N. An all-zero word gives p = 0.
- Code mapping: when gray_sel = 1, out_code = p ^ (p >> 1); when gray_sel = 0, out_code = p. For N = 8 with Gray selected, bits 7 down to 0 map to 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
- out_multi = 1 when popcount(in_data) > 1.
- out_none = 1 when in_data == 0.
- gray_sel travels with its word. A change of gray_sel never alters a word already accepted.
- Stage 1 registers: the priority index i, the none and multi flags, and gray_sel.
- Stage 2 registers: the final code and both flags.
- err_cnt increments by 1 in the cycle a multi-hot word is accepted. It stops at 2^CNT_W - 1.
- If err_clr and an increment happen in the same cycle, err_clr wins and err_cnt becomes 0.

## Timing
- Latency: a word accepted at edge k appears with out_valid = 1 after edge k+2, provided there is no backpressure.
- Throughput: one word per cycle while out_ready = 1.
- Ready chain, combinational:
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready
- Holding: while out_valid = 1 and out_ready = 0, out_code, out_multi and out_none hold stable.
- Full pipe: with both stages full and out_ready = 0, in_ready = 0. Exactly two words are buffered.
- Simultaneous events: when out_ready = 1 and both stages are full, accept, shift and output all happen in one cycle with no bubble.
- out_valid never depends combinationally on out_ready.
- Reset values: out_valid = 0, out_code = 0, out_multi = 0, out_none = 0, err_cnt = 0. Both stage valid bits are 0.
- in_ready is 1 in the first cycle after reset deasserts.
- Reset mid-operation: all buffered words are discarded and never appear on the output. in_ready reads 0 while reset = 1.

## Structure
- Package enc_pkg holds:
  - function code_w(n), returning $clog2(n)+1;
  - function to_gray(logic [31:0]), sliced by the caller;
  - localparam typedef for the stage-1 payload struct (index, none, multi, gray_sel).
- Sub-module prio_scan (combinational): takes in_data and returns the index, none and multi. It is instantiated once, ahead of stage 1.
- Top level contains the two stage registers, the ready chain and the error counter.

## Test plan
- N=8, gray_sel=1, in_data = 8'h80, 8'h40 and 8'h01 back-to-back with out_ready=1. Expected: out_code 0001, 0011, 1100 on three consecutive cycles, starting 2 cycles after the first accept.
- gray_sel=0, in_data = 8'h01. Expected: out_code = 1000, out_multi = 0, out_none = 0.
- in_data = 8'b0010_0100, gray_sel=1. Expected: bit 5 wins, out_code = 0010, out_multi = 1, err_cnt goes from 0 to 1.
- in_data = 8'h00. Expected: out_code = 0000, out_none = 1, err_cnt unchanged.
- Backpressure: out_ready=0, offer 3 words (80, 40, 20). Expected: in_ready drops after 2 accepts and the output holds 0001. Then raise out_ready: expected 0001, 0011, 0010 in order, with no loss or duplication.
- CNT_W=2: 5 multi-hot words. Expected: err_cnt saturates at 3. Assert err_clr in the same cycle as a sixth multi-hot accept: expected err_cnt = 0.
- Assert reset with both stages full. Expected: out_valid = 0 on the next cycle and no stale word afterwards.
